// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared constants for the sequential ALU.
//   - 4-bit ALUOperation encodings (AND..MUL); 1001-1111 are undefined
//     and produce a zero result.
//   - FSM state encoding (IDLE, MUL).
package seq_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one bit per cycle.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset (aborts a run in progress)
//   load    in   capture a/b, clear accumulator and counter, start a run
//   a, b    in   WIDTH-bit operands (only sampled on load)
//   product out  accumulator value including the current iteration; it is
//                the final low-WIDTH product in the cycle done is high
//   done    out  high during the cycle whose edge performs the last iteration
module alu_mul_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] acc_step;

  // Accumulator after this cycle's conditional add; exposing it lets the
  // top register the final product on the same edge as the last iteration.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign product  = acc_step;
  assign done     = run_q && (cnt_q == LAST);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (load) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SHW'(1);
      if (cnt_q == LAST) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a multi-cycle shift-add multiplier.
// Optional feature macro: SEQ_ALU_OVERFLOW_EN (adds the Overflow output).
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   Start        in   request; sampled only when Busy=0
//   ALUOperation in   4-bit opcode (seq_alu_pkg)
//   A, B         in   WIDTH-bit operands; B[SHW-1:0] is the shift amount
//   Busy         out  high while a MUL is iterating
//   Done         out  one-cycle pulse when ALUResult/Zero were just written
//   Zero         out  registered, 1 when ALUResult==0
//   ALUResult    out  registered result, held until the next completion
//   Overflow     out  (SEQ_ALU_OVERFLOW_EN only) signed overflow of ADD/SUB
//   dbg_state_o  out  current FSM state
// Handshake: a request is taken at a rising edge where Start=1 and Busy=0.
// Non-MUL ops complete on that edge (Done in the following cycle); MUL
// completes WIDTH edges later. Start while Busy=1 is dropped, not queued.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic [WIDTH-1:0] ALUResult,
`ifdef SEQ_ALU_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic [0:0]       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] op_res, sum, diff, mul_product;
  logic             slt, mul_load, mul_done;

  assign sum  = A + B;
  assign diff = A - B;
  assign slt  = $signed(A) < $signed(B);

  always_comb begin
    op_res = '0;
    case (ALUOperation)
      OP_AND:  op_res = A & B;
      OP_OR:   op_res = A | B;
      OP_NOR:  op_res = ~(A | B);
      OP_ADD:  op_res = sum;
      OP_SUB:  op_res = diff;
      OP_SLL:  op_res = A << B[SHW-1:0];
      OP_SRL:  op_res = A >> B[SHW-1:0];
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, slt};
      default: op_res = '0;
    endcase
  end

  assign mul_load = (state_q == ST_IDLE) && Start && (ALUOperation == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .a       (A),
    .b       (B),
    .product (mul_product),
    .done    (mul_done)
  );

`ifdef SEQ_ALU_OVERFLOW_EN
  logic ovf_q, ovf_d, op_ovf;

  always_comb begin
    op_ovf = 1'b0;
    if (ALUOperation == OP_ADD) begin
      op_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end else if (ALUOperation == OP_SUB) begin
      op_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    end
  end
`endif

  // Zero is computed from the value being written, never from res_q.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (ALUOperation == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            res_d  = op_res;
            zero_d = (op_res == '0);
            done_d = 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
            ovf_d  = op_ovf;
`endif
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_IDLE;
          res_d   = mul_product;
          zero_d  = (mul_product == '0);
          done_d  = 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
`ifdef SEQ_ALU_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy        = (state_q == ST_MUL);
  assign Done        = done_q;
  assign Zero        = zero_q;
  assign ALUResult   = res_q;
  assign dbg_state_o = state_q;
`ifdef SEQ_ALU_OVERFLOW_EN
  assign Overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        Start;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B, ALUResult;
  logic        Busy, Done, Zero, Overflow;
  logic [0:0]  dbg_state;

  seq_alu #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .Busy         (Busy),
    .Done         (Done),
    .Zero         (Zero),
    .ALUResult    (ALUResult),
`ifdef SEQ_ALU_OVERFLOW_EN
    .Overflow     (Overflow),
`endif
    .dbg_state_o  (dbg_state)
  );

  logic        s8_start;
  logic [3:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_res;
  logic        s8_busy, s8_done, s8_zero, s8_ovf;
  logic [0:0]  s8_dbg;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .Start        (s8_start),
    .ALUOperation (s8_op),
    .A            (s8_a),
    .B            (s8_b),
    .Busy         (s8_busy),
    .Done         (s8_done),
    .Zero         (s8_zero),
    .ALUResult    (s8_res),
`ifdef SEQ_ALU_OVERFLOW_EN
    .Overflow     (s8_ovf),
`endif
    .dbg_state_o  (s8_dbg)
  );

`ifndef SEQ_ALU_OVERFLOW_EN
  assign Overflow = 1'b0;
  assign s8_ovf   = 1'b0;
`endif

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (32-bit instance) ----------------
  // Returns {overflow, result} straight from the arithmetic definitions.
  function automatic logic [32:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'h0;
    o  = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a | b);
      4'd3: begin s = sa + sb; r = s[31:0]; o = (longint'($signed(r)) != s); end
      4'd4: begin s = sa - sb; r = s[31:0]; o = (longint'($signed(r)) != s); end
      4'd5: r = a << (b % 32);
      4'd6: r = a >> (b % 32);
      4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    return {o, r};
  endfunction

  logic [31:0] m_res  = 32'h0;
  logic [31:0] m_pres = 32'h0;
  logic        m_ovf  = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;
  int          m_left = 0;

  // Transaction-level model: a MUL is a pending result that lands WIDTH
  // edges after acceptance; anything else lands on the accepting edge.
  always @(posedge clk or negedge reset) begin : model
    logic [32:0]     r;
    longint unsigned p;
    if (!reset) begin
      m_res  <= 32'h0;
      m_pres <= 32'h0;
      m_ovf  <= 1'b0;
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_res  <= m_pres;
          m_ovf  <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (Start) begin
        if (ALUOperation == 4'd8) begin
          p = 64'(A) * 64'(B);
          m_busy <= 1'b1;
          m_left <= 32;
          m_pres <= p[31:0];
        end else begin
          r = model_op(ALUOperation, A, B);
          m_res  <= r[31:0];
          m_ovf  <= r[32];
          m_done <= 1'b1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset && cmp_en) begin
      chk("cyc_done", Done, m_done);
      chk("cyc_busy", Busy, m_busy);
      chk("cyc_result", ALUResult, m_res);
      chk("cyc_zero", Zero, m_res == 32'h0);
`ifdef SEQ_ALU_OVERFLOW_EN
      chk("cyc_ovf", Overflow, m_ovf);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of the Done cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string nm);
    int n;
    Start = 1'b1; ALUOperation = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
    n = 1;
    while (!Done && n < exp_lat + 8) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_res"}, ALUResult, exp_res);
    chk({nm, "_zero"}, Zero, exp_res == 32'h0);
  endtask

  task automatic run_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input int exp_lat, input string nm);
    int n;
    s8_start = 1'b1; s8_op = op; s8_a = a; s8_b = b;
    @(negedge clk);
    s8_start = 1'b0;
    n = 1;
    while (!s8_done && n < exp_lat + 8) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_res"}, s8_res, exp_res);
    chk({nm, "_zero"}, s8_zero, exp_res == 8'h0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1: begin
        case ($urandom_range(0, 3))
          0:       return 32'h7FFF_FFFF;
          1:       return 32'h8000_0000;
          2:       return 32'hFFFF_FFFF;
          default: return 32'h0;
        endcase
      end
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    logic saw_done;
    Start = 1'b0; ALUOperation = 4'd0; A = 32'h0; B = 32'h0;
    s8_start = 1'b0; s8_op = 4'd0; s8_a = 8'h0; s8_b = 8'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_result", ALUResult, 32'h0);
    chk("rst_zero", Zero, 1'b1);
    chk("rst_ovf", Overflow, 1'b0);
    reset  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Directed single-cycle ops with hand-computed results.
    run_op(4'b0100, 32'd5, 32'd5, 32'h0, 1, "sub_eq");
    run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, "add_wrap");
    run_op(4'b0111, 32'hFFFF_FFFE, 32'd1, 32'd1, 1, "slt_neg");
    run_op(4'b0110, 32'h8000_0000, 32'd31, 32'd1, 1, "srl31");
    run_op(4'b0101, 32'd1, 32'h3F, 32'h8000_0000, 1, "sll_mask");
    run_op(4'b0010, 32'h0, 32'h0, 32'hFFFF_FFFF, 1, "nor");
    run_op(4'b1111, 32'd5, 32'd6, 32'h0, 1, "undef");

`ifdef SEQ_ALU_OVERFLOW_EN
    run_op(4'b0011, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, "ovf_add");
    chk("ovf_add_flag", Overflow, 1'b1);
    run_op(4'b0100, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1, "ovf_sub");
    chk("ovf_sub_flag", Overflow, 1'b1);
    run_op(4'b0011, 32'd1, 32'd1, 32'd2, 1, "ovf_none");
    chk("ovf_none_flag", Overflow, 1'b0);
`endif

    // MUL with an ignored Start during Busy and a back-to-back Start in Done.
    Start = 1'b1; ALUOperation = 4'b1000; A = 32'd1234; B = 32'd5678;
    @(negedge clk);
    n = 1;
    while (!Done && n < 60) begin
      if (n == 5) begin
        Start = 1'b1; ALUOperation = 4'b0011; A = 32'd1; B = 32'd2;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("mul_lat", n, 33);
    chk("mul_res", ALUResult, 32'd7006652);
    chk("mul_model_pin", m_res, 32'd7006652);
    chk("mul_busy_in_done", Busy, 1'b0);
    Start = 1'b1; ALUOperation = 4'b0011; A = 32'd3; B = 32'd4;
    @(negedge clk);
    Start = 1'b0;
    chk("b2b_done", Done, 1'b1);
    chk("b2b_res", ALUResult, 32'd7);
    @(negedge clk);
    chk("b2b_single_pulse", Done, 1'b0);

    // Reset three cycles into a MUL: aborted, no Done afterwards.
    Start = 1'b1; ALUOperation = 4'b1000; A = 32'd7; B = 32'd9;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", Busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_result", ALUResult, 32'h0);
    chk("abort_zero", Zero, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);

    // 8-bit instance.
    run_op8(4'b1000, 8'h10, 8'h10, 8'h00, 9, "w8_mul_wrap");
    run_op8(4'b1000, 8'd13, 8'd11, 8'd143, 9, "w8_mul");
    run_op8(4'b1111, 8'h55, 8'hAA, 8'h00, 1, "w8_undef");
    run_op8(4'b0011, 8'hFF, 8'h02, 8'h01, 1, "w8_add_wrap");

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      Start = ($urandom_range(0, 2) == 0);
      ALUOperation = 4'($urandom_range(0, 15));
      A = rand_operand();
      B = rand_operand();
      if (i == 1500) begin
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 32-bit combinational ALU in the datapath.
- Adds shift, set-less-than, and an iterative shift-add multiplier.
- Uses a Start/Busy/Done handshake so the multi-cycle controller can stall on MUL.
- Sits between the register-file read ports and the write-back mux.

Parameters:
- WIDTH, 32, operand and result width in bits (power of two, ≥8).
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  request pulse; sampled when Busy=0.
- ALUOperation  input  4  operation code (see package).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for SLL/SRL.
- Busy  output  1  high while a multi-cycle MUL is in progress.
- Done  output  1  one-cycle pulse: ALUResult/Zero updated.
- Zero  output  1  registered; 1 when ALUResult==0.
- ALUResult  output  WIDTH  registered result, held until next completion.

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is asynchronous and active-low.
- Reset (reset=0): state=IDLE, Busy=0, Done=0, ALUResult=0, Zero=1, multiplier registers=0. Takes effect immediately, including mid-MUL; the MUL is aborted with no Done.
- Opcodes:
  - AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100 (existing encodings kept).
  - SLL 0101, SRL 0110 (logical; shift ≥ WIDTH impossible since SHW bits).
  - SLT 0111: signed compare, result 1 if $signed(A)<$signed(B), else 0.
  - MUL 1000: unsigned, low WIDTH bits of A*B.
  - 1001-1111: undefined, result 0.
- ADD/SUB wrap modulo 2^WIDTH.
- States:
  - IDLE: Start=1 with non-MUL op at edge k → ALUResult, Zero written at edge k; Done=1 during cycle k+1; stay IDLE.
  - IDLE → MUL: Start=1 with ALUOperation=MUL at edge k → capture A into multiplicand, B into multiplier, clear accumulator and counter. Busy=1 from cycle k+1.
  - MUL: each edge adds multiplicand to the accumulator if multiplier[0]=1, shifts multiplicand left and multiplier right by 1, and increments the counter.
  - MUL → IDLE: after WIDTH iterations (edge k+WIDTH), ALUResult=accumulator and Zero are updated, Done=1 during cycle k+WIDTH+1, Busy=0 in that same cycle.
- Latency: non-MUL 1 cycle; MUL WIDTH+1 cycles (Start edge to Done cycle).
- Done is never high for two consecutive cycles from the same op. A new Start in a Done cycle is accepted (back-to-back).
- Start while Busy=1: ignored. No queueing; A/B/op changes during MUL have no effect.
- Undefined op with Start: ALUResult=0, Zero=1, Done pulses (no hang).
- Zero always derives from the value being written to ALUResult, never from stale data.
- Outputs hold their values between completions; Start=0 in IDLE changes nothing.

Optional Feature:
- Macro SEQ_ALU_OVERFLOW_EN.
- Defined: adds output port Overflow (1 bit, reset 0), registered with ALUResult.
  - ADD: set when operand signs are equal and the result sign differs.
  - SUB: set when operand signs differ and the result sign differs from A.
  - All other ops (including MUL): 0.
- Undefined: port absent and no overflow logic is synthesised; all other behaviour is identical.

Decomposition:
- Package seq_alu_pkg: 4-bit opcode constants (AND..MUL), state encoding (IDLE, MUL).
- Sub-module alu_mul_iter:
  - Inputs: clk, reset, load, a, b.
  - Outputs: product, done.
  - Contents: iterative datapath and counter.
- seq_alu keeps the combinational single-cycle ops, the FSM and the output registers.

Test Plan:
- WIDTH=32, reset low mid-MUL (3 cycles after Start, A=7, B=9) → Busy=0, Done never pulses, ALUResult=0, Zero=1.
- Start SUB A=5 B=5 → next cycle Done=1, ALUResult=0, Zero=1. Start ADD A=0xFFFFFFFF B=1 → ALUResult=0, Zero=1 (wrap).
- Start SLT A=0xFFFFFFFE(-2) B=1 → ALUResult=1. Start SRL A=0x80000000 B=31 → 1. Start SLL A=1 B=0x3F → 0x80000000 (only B[4:0] used).
- Start MUL A=1234 B=5678 → Busy=1 for 32 cycles, Done in cycle 33, ALUResult=7006652. A second Start ADD during Busy is ignored; a Start ADD in the Done cycle completes one cycle later.
- WIDTH=8: MUL A=0x10 B=0x10 → ALUResult=0x00, Zero=1, latency 9 cycles. ALUOperation=1111 → ALUResult=0, Done pulses.
- With SEQ_ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 → Overflow=1. SUB 0x80000000-1 → Overflow=1. ADD 1+1 → Overflow=0.
